// File: rtl/ram_cmd_arbiter.sv
// rtl/ram_cmd_arbiter.sv - two-requester round-robin arbiter issuing address/data commands to a RAM
module ram_cmd_arbiter #(
  parameter int TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] we,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic [1:0] done,
  output logic [7:0] rdata,
  output logic       err,
  output logic       busy,
  output logic [9:0] ram_din,
  output logic       ram_rx_valid,
  input  logic [7:0] ram_dout,
  input  logic       ram_tx_valid
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  // Last WAIT cycle index; TIMEOUT wait cycles in total before aborting.
  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

  logic [2:0] state;
  logic       owner;
  logic       last_served;
  logic       we_q;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic [7:0] rdata_q;
  logic       err_q;
  logic [3:0] wait_cnt;
  logic       winner;

  // A lone request always wins; contention goes to whoever was not served last.
  always_comb begin
    winner = 1'b0;
    case (req)
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_served;
      default: winner = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      owner       <= 1'b0;
      last_served <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
      rdata_q     <= 8'h00;
      err_q       <= 1'b0;
      wait_cnt    <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            owner    <= winner;
            we_q     <= winner ? we[1] : we[0];
            addr_q   <= winner ? addr1 : addr0;
            wdata_q  <= winner ? wdata1 : wdata0;
            rdata_q  <= 8'h00;
            err_q    <= 1'b0;
            wait_cnt <= 4'd0;
            state    <= S_ADDR;
          end
        end
        S_ADDR: state <= S_DATA;
        S_DATA: state <= we_q ? S_RESP : S_WAIT;
        S_WAIT: begin
          if (ram_tx_valid) begin
            rdata_q <= ram_dout;
            err_q   <= 1'b0;
            state   <= S_RESP;
          end else if (wait_cnt == WAIT_LAST) begin
            rdata_q <= 8'h00;
            err_q   <= 1'b1;
            state   <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_RESP: begin
          last_served <= owner;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs depend only on state and latched registers, never directly on inputs.
  always_comb begin
    busy         = (state != S_IDLE);
    ram_rx_valid = 1'b0;
    ram_din      = 10'h000;
    done         = 2'b00;
    rdata        = 8'h00;
    err          = 1'b0;
    case (state)
      S_ADDR: begin
        ram_rx_valid = 1'b1;
        ram_din      = we_q ? {2'b00, addr_q} : {2'b10, addr_q};
      end
      S_DATA: begin
        ram_rx_valid = 1'b1;
        ram_din      = we_q ? {2'b01, wdata_q} : {2'b11, 8'h00};
      end
      S_RESP: begin
        done  = owner ? 2'b10 : 2'b01;
        rdata = rdata_q;
        err   = err_q;
      end
      default: ;
    endcase
  end

endmodule
